// File: rtl/wb_hyperram_post_buffer.sv
`timescale 1ns/1ps
// Wishbone write-posting bridge in front of wb_hyperram: writes are queued and acked early.
// Latency: write ack 1 cycle after accept; read ack 1 cycle after the downstream ack.
// Backpressure: writes stall while the FIFO is full; reads wait for an empty FIFO and idle FSM.
module wb_hyperram_post_buffer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_dat_o,
  output logic [31:0]      wbm_adr_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic [LVL_W-1:0] fifo_level_o,
  output logic             busy_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_RACK} state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_ent_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             wbs_ack_q, wbs_ack_d;
  logic [31:0]      wbs_dat_q, wbs_dat_d;
  logic             wbm_cyc_q, wbm_cyc_d;
  logic             wbm_we_q, wbm_we_d;
  logic [3:0]       wbm_sel_q, wbm_sel_d;
  logic [31:0]      wbm_dat_q, wbm_dat_d;
  logic [31:0]      wbm_adr_q, wbm_adr_d;

  wr_ent_t fifo_mem_q [DEPTH];
  wr_ent_t head;

  logic accept, push, pop, fifo_empty, fifo_full;

  // Upstream handshake and FIFO occupancy; full comes from the registered count only.
  always_comb begin
    accept     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_q;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == LVL_W'(DEPTH));
    push       = accept & wbs_we_i & ~fifo_full;
    pop        = (state_q == ST_WR) & wbm_ack_i;
    head       = fifo_mem_q[rd_ptr_q];
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + LVL_W'(push) - LVL_W'(pop);
  end

  // Downstream sequencer: drain posted writes first, then pass a read through.
  always_comb begin
    state_d   = state_q;
    wbs_ack_d = push;
    wbs_dat_d = wbs_dat_q;
    wbm_cyc_d = wbm_cyc_q;
    wbm_we_d  = wbm_we_q;
    wbm_sel_d = wbm_sel_q;
    wbm_dat_d = wbm_dat_q;
    wbm_adr_d = wbm_adr_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d   = ST_WR;
          wbm_cyc_d = 1'b1;
          wbm_we_d  = 1'b1;
          wbm_adr_d = head.adr;
          wbm_dat_d = head.dat;
          wbm_sel_d = head.sel;
        end else if (accept && !wbs_we_i) begin
          state_d   = ST_RD;
          wbm_cyc_d = 1'b1;
          wbm_we_d  = 1'b0;
          wbm_adr_d = wbs_adr_i;
          wbm_sel_d = wbs_sel_i;
          wbm_dat_d = '0;
        end
      end
      ST_WR: begin
        if (wbm_ack_i) begin
          state_d   = ST_IDLE;
          wbm_cyc_d = 1'b0;
          wbm_we_d  = 1'b0;
        end
      end
      ST_RD: begin
        if (wbm_ack_i) begin
          state_d   = ST_RACK;
          wbm_cyc_d = 1'b0;
          // An abandoned read (cyc dropped, or a new write already pushing) gets no data and no ack.
          if (wbs_cyc_i && !push) begin
            wbs_ack_d = 1'b1;
            wbs_dat_d = wbm_dat_i;
          end
        end
      end
      ST_RACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All control state and registered outputs; reset drops any open cycle and empties the FIFO.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wbs_ack_q <= 1'b0;
      wbs_dat_q <= '0;
      wbm_cyc_q <= 1'b0;
      wbm_we_q  <= 1'b0;
      wbm_sel_q <= '0;
      wbm_dat_q <= '0;
      wbm_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wbs_ack_q <= wbs_ack_d;
      wbs_dat_q <= wbs_dat_d;
      wbm_cyc_q <= wbm_cyc_d;
      wbm_we_q  <= wbm_we_d;
      wbm_sel_q <= wbm_sel_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_adr_q <= wbm_adr_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= '{adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i};
    end
  end

  assign wbs_ack_o    = wbs_ack_q;
  assign wbs_dat_o    = wbs_dat_q;
  assign wbm_cyc_o    = wbm_cyc_q;
  assign wbm_stb_o    = wbm_cyc_q;
  assign wbm_we_o     = wbm_we_q;
  assign wbm_sel_o    = wbm_sel_q;
  assign wbm_dat_o    = wbm_dat_q;
  assign wbm_adr_o    = wbm_adr_q;
  assign fifo_level_o = count_q;
  assign busy_o       = (count_q != '0) | wbm_cyc_q;

endmodule
